// File: rtl/bram_bank_arbiter_if.sv
// Requester-side port of the BRAM bank arbiter: access handshake
// plus the read-return channel for one requester.
interface bram_bank_arbiter_if #(
    parameter int AW = 14,
    parameter int DW = 128
);
    logic          valid;
    logic          ready;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (
        output valid, we, addr, wdata,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  valid, we, addr, wdata,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/bram_bank_arbiter.sv
// Round-robin arbiter sharing one BRAM bank port between a stream
// requester (A) and a compute requester (B), with read return routing.
module bram_bank_arbiter #(
    parameter int AW     = 14,
    parameter int DW     = 128,
    parameter int RD_LAT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                hold,
    bram_bank_arbiter_if.slave  a,
    bram_bank_arbiter_if.slave  b,
    output logic [AW-1:0]       addr,
    output logic [DW-1:0]       din,
    output logic                we,
    input  logic [DW-1:0]       dout,
    output logic                busy
);
    localparam int DEPTH = RD_LAT + 1;

    logic             prio;
    logic             gnt_a;
    logic             gnt_b;
    logic             acc;
    logic             win_we;
    logic [AW-1:0]    win_addr;
    logic [DW-1:0]    win_wdata;
    logic [DEPTH-1:0] pv;
    logic [DEPTH-1:0] pid;
    logic             ret_a;
    logic             ret_b;

    // prio breaks ties only; a lone requester always wins
    always_comb begin
        gnt_a = rst_n & ~hold & a.valid & (~b.valid | ~prio);
        gnt_b = rst_n & ~hold & b.valid & (~a.valid | prio);
    end

    assign a.ready = gnt_a;
    assign b.ready = gnt_b;
    assign acc     = gnt_a | gnt_b;

    always_comb begin
        win_we    = gnt_b ? b.we    : a.we;
        win_addr  = gnt_b ? b.addr  : a.addr;
        win_wdata = gnt_b ? b.wdata : a.wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= 1'b0;
        end else if (acc) begin
            prio <= gnt_a;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
            din  <= '0;
            we   <= 1'b0;
        end else if (acc) begin
            addr <= win_addr;
            din  <= win_wdata;
            we   <= win_we;
        end else begin
            we   <= 1'b0;
        end
    end

    // One stage per cycle of BRAM latency plus the return register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv  <= '0;
            pid <= '0;
        end else begin
            pv  <= {pv[DEPTH-2:0], acc & ~win_we};
            pid <= {pid[DEPTH-2:0], gnt_b};
        end
    end

    assign ret_a = pv[DEPTH-1] & ~pid[DEPTH-1];
    assign ret_b = pv[DEPTH-1] & pid[DEPTH-1];
    assign busy  = |pv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a.rvalid <= 1'b0;
            b.rvalid <= 1'b0;
            a.rdata  <= '0;
            b.rdata  <= '0;
        end else begin
            a.rvalid <= ret_a;
            b.rvalid <= ret_b;
            if (ret_a) a.rdata <= dout;
            if (ret_b) b.rdata <= dout;
        end
    end
endmodule

// File: tb/tb_bram_bank_arbiter.sv
// Scoreboard bench: three arbiters (RD_LAT 2, 1, 4) share one stimulus
// stream, each behind its own BRAM model.
module tb_bram_bank_arbiter;
    typedef struct {
        int           acc;
        bit           id;
        logic [127:0] d;
    } rd_t;

    logic         clk;
    logic         rst_n;
    logic         hold;
    logic         a_valid, a_we, b_valid, b_we;
    logic [13:0]  a_addr, b_addr;
    logic [127:0] a_wdata, b_wdata;

    logic [13:0]  addr_o  [3];
    logic [127:0] din_o   [3];
    logic         we_o    [3];
    logic         busy_o  [3];
    logic         a_rdy_o [3];
    logic         b_rdy_o [3];

    int           n_vec = 0;
    int           n_err = 0;
    int           ecount = 0;
    bit           prio_m = 0;
    bit           we_m = 0;
    rd_t          rec[$];
    int           glog[$];
    logic [127:0] shadow[int];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [127:0] initval(int ad);
        logic [15:0] w;
        if (ad == 16'h0010) return {16{8'hA5}};
        w = {2'b10, ad[13:0]};
        return {8{w}};
    endfunction

    function automatic logic [127:0] shadow_rd(int ad);
        if (shadow.exists(ad)) return shadow[ad];
        return initval(ad);
    endfunction

    function automatic bit exp_ga();
        return rst_n & ~hold & a_valid & (~b_valid | ~prio_m);
    endfunction

    function automatic bit exp_gb();
        return rst_n & ~hold & b_valid & (~a_valid | prio_m);
    endfunction

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference model: grants, priority, write strobe, expected reads
    initial forever begin
        bit ga, gb;
        @(posedge clk);
        ecount++;
        if (!rst_n) begin
            prio_m = 0;
            we_m   = 0;
        end else begin
            ga   = exp_ga();
            gb   = exp_gb();
            we_m = 0;
            if (ga) begin
                prio_m = 1;
                if (a_we) begin
                    shadow[int'(a_addr)] = a_wdata;
                    we_m = 1;
                end else begin
                    rec.push_back('{ecount, 1'b0, shadow_rd(int'(a_addr))});
                end
            end else if (gb) begin
                prio_m = 0;
                if (b_we) begin
                    shadow[int'(b_addr)] = b_wdata;
                    we_m = 1;
                end else begin
                    rec.push_back('{ecount, 1'b1, shadow_rd(int'(b_addr))});
                end
            end
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 4;

        bram_bank_arbiter_if #(.AW(14), .DW(128)) ifa ();
        bram_bank_arbiter_if #(.AW(14), .DW(128)) ifb ();

        logic [127:0] dout;
        logic [127:0] pl [0:3];
        logic [127:0] mem[int];
        int           ptr = 0;
        logic [127:0] last_a = '0;
        logic [127:0] last_b = '0;

        assign ifa.valid = a_valid;
        assign ifa.we    = a_we;
        assign ifa.addr  = a_addr;
        assign ifa.wdata = a_wdata;
        assign ifb.valid = b_valid;
        assign ifb.we    = b_we;
        assign ifb.addr  = b_addr;
        assign ifb.wdata = b_wdata;
        assign a_rdy_o[g] = ifa.ready;
        assign b_rdy_o[g] = ifb.ready;
        assign dout = pl[L-1];

        bram_bank_arbiter #(.AW(14), .DW(128), .RD_LAT(L)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .hold  (hold),
            .a     (ifa),
            .b     (ifb),
            .addr  (addr_o[g]),
            .din   (din_o[g]),
            .we    (we_o[g]),
            .dout  (dout),
            .busy  (busy_o[g])
        );

        // BRAM model, read-first, L cycles from address to dout
        initial forever begin
            logic [127:0] rd;
            int ad;
            @(posedge clk);
            ad = int'(addr_o[g]);
            rd = mem.exists(ad) ? mem[ad] : initval(ad);
            if (we_o[g]) mem[ad] = din_o[g];
            pl[0] <= rd;
            for (int i = 1; i < 4; i++) pl[i] <= pl[i-1];
        end

        initial forever begin
            bit busy_e;
            string p;
            @(negedge clk);
            p = $sformatf("L%0d", L);
            if (!rst_n) begin
                ptr = rec.size();
                last_a = '0;
                last_b = '0;
                chk({p, " reset_outputs"},
                    128'({addr_o[g], din_o[g][7:0], we_o[g], busy_o[g],
                          ifa.ready, ifb.ready, ifa.rvalid, ifb.rvalid,
                          |ifa.rdata, |ifb.rdata}), 128'd0);
            end else begin
                busy_e = 0;
                for (int i = ptr; i < rec.size(); i++)
                    if (rec[i].acc + L + 1 > ecount) busy_e = 1;
                chk({p, " busy"}, 128'(busy_o[g]), 128'(busy_e));
                chk({p, " a_ready"}, 128'(ifa.ready), 128'(exp_ga()));
                chk({p, " b_ready"}, 128'(ifb.ready), 128'(exp_gb()));
                chk({p, " we"}, 128'(we_o[g]), 128'(we_m));
                if (ifa.rvalid && ifb.rvalid)
                    chk({p, " rvalid_both"}, 128'd1, 128'd0);
                if (ifa.rvalid || ifb.rvalid) begin
                    if (ptr >= rec.size()) begin
                        chk({p, " rvalid_unexpected"}, 128'd1, 128'd0);
                    end else begin
                        chk({p, " rvalid_id"}, 128'(ifb.rvalid),
                            128'(rec[ptr].id));
                        chk({p, " rd_latency"}, 128'(ecount - rec[ptr].acc),
                            128'(L + 1));
                        if (rec[ptr].id) last_b = rec[ptr].d;
                        else last_a = rec[ptr].d;
                        ptr++;
                    end
                end
                chk({p, " a_rdata"}, ifa.rdata, last_a);
                chk({p, " b_rdata"}, ifb.rdata, last_b);
                while (ptr < rec.size() && rec[ptr].acc + L + 1 < ecount) begin
                    chk({p, " rvalid_missing"}, 128'd0, 128'd1);
                    ptr++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present requests until both are accepted, logging DUT grants
    task automatic serve(int max);
        bit ra, rb;
        for (int i = 0; i < max && (a_valid || b_valid); i++) begin
            #1;
            ra = a_rdy_o[0];
            rb = b_rdy_o[0];
            if (ra) glog.push_back(0);
            if (rb) glog.push_back(1);
            @(posedge clk);
            #1;
            if (ra) a_valid = 0;
            if (rb) b_valid = 0;
        end
        if (a_valid || b_valid)
            chk("serve_timeout", 128'd1, 128'd0);
        a_valid = 0;
        b_valid = 0;
    endtask

    task automatic rd_a(logic [13:0] ad);
        a_valid = 1; a_we = 0; a_addr = ad;
    endtask

    task automatic rd_b(logic [13:0] ad);
        b_valid = 1; b_we = 0; b_addr = ad;
    endtask

    initial begin
        int ia, ib;
        int exp_ord [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
        rst_n = 0; hold = 0;
        a_valid = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_valid = 0; b_we = 0; b_addr = '0; b_wdata = '0;
        repeat (3) step();
        rst_n = 1;
        step();

        // Contention from reset: A first, strict alternation
        glog.delete();
        ia = 0; ib = 0;
        for (int i = 0; i < 20 && (ia < 4 || ib < 4); i++) begin
            a_valid = (ia < 4); a_we = 0; a_addr = 14'(1 + ia);
            b_valid = (ib < 4); b_we = 0; b_addr = 14'(14'h101 + ib);
            #1;
            if (a_rdy_o[0]) begin glog.push_back(0); ia++; end
            if (b_rdy_o[0]) begin glog.push_back(1); ib++; end
            step();
        end
        a_valid = 0; b_valid = 0;
        chk("contention_grants", 128'(glog.size()), 128'd8);
        for (int i = 0; i < 8 && i < glog.size(); i++)
            chk($sformatf("grant_order_%0d", i), 128'(glog[i]),
                128'(exp_ord[i]));
        repeat (2) step();
        chk("busy_before_drain", 128'(busy_o[0]), 128'd1);
        step();
        chk("busy_3_after_last", 128'(busy_o[0]), 128'd0);
        repeat (4) step();

        // Single read of the preloaded word
        rd_a(14'h0010);
        serve(4);
        repeat (6) step();

        // Write then read at the top address
        b_valid = 1; b_we = 1; b_addr = 14'h3FFF; b_wdata = 128'h1234;
        step();
        b_valid = 0;
        chk("we_after_write", 128'(we_o[0]), 128'd1);
        chk("addr_after_write", 128'(addr_o[0]), 128'h3FFF);
        rd_a(14'h3FFF);
        step();
        a_valid = 0;
        chk("we_one_cycle", 128'(we_o[0]), 128'd0);
        repeat (6) step();

        // Hold with both valid; B read first leaves prio at A
        rd_b(14'h0200);
        serve(4);
        hold = 1;
        rd_a(14'h0020);
        rd_b(14'h0120);
        repeat (5) begin
            #1;
            chk("hold_no_grant",
                128'({a_rdy_o[0], b_rdy_o[0]}), 128'd0);
            step();
        end
        hold = 0;
        #1;
        chk("post_hold_grant",
            128'({a_rdy_o[0], b_rdy_o[0]}), 128'b10);
        serve(6);
        repeat (6) step();

        // Reset with a read and a write in flight
        rd_a(14'h0030);
        step();
        a_valid = 0;
        b_valid = 1; b_we = 1; b_addr = 14'h0050; b_wdata = 128'hDEAD;
        step();
        b_valid = 0;
        chk("we_before_reset", 128'(we_o[0]), 128'd1);
        rst_n = 0;
        #1;
        for (int g = 0; g < 3; g++)
            chk($sformatf("async_we_drop_%0d", g), 128'(we_o[g]), 128'd0);
        repeat (3) step();
        rst_n = 1;
        step();
        rd_a(14'h0060);
        rd_b(14'h0160);
        #1;
        chk("post_reset_grant",
            128'({a_rdy_o[0], b_rdy_o[0]}), 128'b10);
        serve(6);
        repeat (10) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/bram_bank_arbiter.md
# bram_bank_arbiter

Two-requester arbiter that shares a single BRAM bank port (the `addr_*`/`din_*`/`dout_*`/`we_*` group driven by the stream interface) between a stream-side requester (A) and a compute-side requester (B). Grants one access per cycle with round-robin priority under contention and registers the BRAM port signals. Tracks outstanding reads through a latency pipeline and returns each read word only to the requester that issued it. One instance sits in front of each bank, low and high.

## Interface
- `AW`, 14, BRAM address width.
- `DW`, 128, BRAM data width.
- `RD_LAT`, 2, BRAM read latency in cycles from address presented to `dout` valid; legal range 1..4.

- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `hold`  in  1  when high, no new grants (pending reads still complete).
- `a_valid`  in  1  requester A access request.
- `a_ready`  out  1  A granted this cycle (combinational).
- `a_we`  in  1  1 = write, 0 = read.
- `a_addr`  in  AW  A address.
- `a_wdata`  in  DW  A write data.
- `a_rvalid`  out  1  A read data valid, one-cycle pulse.
- `a_rdata`  out  DW  A read data.
- `b_valid`, `b_ready`, `b_we`, `b_addr`, `b_wdata`, `b_rvalid`, `b_rdata`: same as A, for requester B.
- `addr`  out  AW  BRAM address (registered).
- `din`  out  DW  BRAM write data (registered).
- `we`  out  1  BRAM write enable (registered).
- `dout`  in  DW  BRAM read data.
- `busy`  out  1  high while any read is in flight.

## Operation
- Accept on A = `a_valid & a_ready` at a rising edge; same for B. At most one accept per edge.
- Grant rule (combinational, inputs this cycle):
  - No grant when `hold` is high or `rst_n` is low.
  - If only one requester is valid, grant that requester.
  - If both are valid, grant the one selected by the priority pointer `prio` (0 = A, 1 = B).
  - Ready is never high for a non-valid requester.
- `prio` update: after an A accept, `prio`←1. After a B accept, `prio`←0. Otherwise unchanged.
- BRAM port: on accept, `addr`/`din`/`we` load the winner's `addr`/`wdata`/`we`. With no accept, `we`←0 and `addr`/`din` hold their values.
- Read tracking: shift register of depth `RD_LAT`+1, each stage holding {valid, id}.
  - Stage 0 loads {accept & ~we, winner id}.
  - At the final stage, if valid, `dout` is captured into `x_rdata` of the requester named by id, and `x_rvalid` pulses.
  - `x_rdata` holds its value between pulses.
- `busy` = OR of all pipeline valid bits.
- Writes produce no response.
- No read-after-write hazard handling: the BRAM's own write-first/read-first mode applies.

## Timing
- Reset (async assert, sync release): `addr`=0, `din`=0, `we`=0, `prio`=0, all pipeline valids 0, `a_rvalid`=`b_rvalid`=0, `a_rdata`=`b_rdata`=0, `busy`=0. `a_ready`/`b_ready`=0 while `rst_n` is low.
- Write accepted at edge N: `we`=1 with the address and data during cycle N..N+1, so the BRAM writes at edge N+1.
- Read accepted at edge N:
  - `addr` is presented from edge N.
  - `dout` is valid after edge N+`RD_LAT`.
  - `x_rvalid`=1 and `x_rdata` valid for exactly the cycle after edge N+`RD_LAT`+1.
  - Total latency is `RD_LAT`+1 edges.
- Throughput: one access per cycle, sustained. Back-to-back reads from alternating requesters return in issue order, each to its own port.
- Simultaneous valid on both: winner is `prio`. Under continuous contention the grants alternate A,B,A,B starting from the reset value (A first).
- `hold` rising with both valid: no accept that cycle, and `prio` is unchanged.
- Reset mid-operation: in-flight reads are discarded and no `rvalid` is issued for them. `we` drops immediately (asynchronously).
- Requester deasserting valid while ungranted is allowed; no state is kept for it.

## Test plan
- Single read: preload BRAM[0x0010]=128'hA5…A5, `RD_LAT`=2. A read 0x0010 accepted at edge 5 -> `a_rvalid` high in the cycle after edge 8 with `a_rdata`=A5…A5; `b_rvalid` stays 0.
- Contention: A and B both assert valid continuously with reads of 0x1..0x4 and 0x101..0x104 -> grants alternate A,B,A,B…; every `rvalid` pulse carries the data of its own address; 8 pulses total; `busy` low 3 cycles after the last accept.
- Write then read: B writes 0x3FFF=128'h1234 at edge 10, A reads 0x3FFF at edge 11 -> `a_rdata`=128'h1234; `we` high for exactly one cycle.
- Hold: `hold`=1 for 5 cycles with both requesters valid -> no accepts and `we`=0; after release, A is granted first if `prio` was 0.
- Reset mid-flight: assert `rst_n`=0 one cycle after a read is accepted -> no `rvalid` ever appears for it; all outputs return to reset values; the first post-reset contention is granted to A.
- Sweep `RD_LAT`=1 and 4: measured accept-to-`rvalid` latency is 2 and 5 edges respectively.
